// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave oven controller: state codes, time constants
// and the saturating time adder.
package microwave_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [9:0] ADD_SEC = 10'd30;
    localparam logic [9:0] MAX_SEC = 10'd990;

    function automatic logic [9:0] sat_add(input logic [9:0] t, input logic [9:0] inc);
        logic [10:0] sum;
        sum = {1'b0, t} + {1'b0, inc};
        return (sum > {1'b0, MAX_SEC}) ? MAX_SEC : sum[9:0];
    endfunction

endpackage

// File: rtl/btn_pulse.sv
// Two-flop synchronizer plus rising-edge detector: one clock-wide pulse per button press.
module btn_pulse (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // prev_q clears in reset so a button held through release still yields one pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave oven controller: button/door handling, cook-time register, 1 s prescaler
// and the IDLE/SET/COOK/PAUSE/DONE sequencer.
module microwave_ctrl
    import microwave_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int BUZZ_SEC = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_add,
    input  logic       door_open,
    output logic       magnetron,
    output logic       lamp,
    output logic       buzzer,
    output logic [9:0] time_left,
    output logic [2:0] state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BUZZ_SEC > 1) ? $clog2(BUZZ_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BUZZ_LAST  = BW'(BUZZ_SEC - 1);

    logic          start_p;
    logic          stop_p;
    logic          add_p;
    logic          door_s1_q;
    logic          door_s2_q;
    state_e        state_q;
    logic [9:0]    time_q;
    logic [PW-1:0] presc_q;
    logic [BW-1:0] buzz_q;
    logic          buzzer_q;
    logic          counting;
    logic          tick;

    btn_pulse u_start (.clk(clk), .reset(reset), .btn_i(btn_start), .pulse_o(start_p));
    btn_pulse u_stop  (.clk(clk), .reset(reset), .btn_i(btn_stop),  .pulse_o(stop_p));
    btn_pulse u_add   (.clk(clk), .reset(reset), .btn_i(btn_add),   .pulse_o(add_p));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            door_s1_q <= 1'b0;
            door_s2_q <= 1'b0;
        end else begin
            door_s1_q <= door_open;
            door_s2_q <= door_s1_q;
        end
    end

    assign counting = (state_q == S_COOK) || (state_q == S_DONE);
    assign tick     = counting && (presc_q == PRESC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            time_q   <= '0;
            presc_q  <= '0;
            buzz_q   <= '0;
            buzzer_q <= 1'b0;
        end else begin
            // Prescaler runs in COOK/DONE, freezes in PAUSE; entries below force it to 0
            if (counting) begin
                presc_q <= tick ? '0 : presc_q + 1'b1;
            end else if (state_q != S_PAUSE) begin
                presc_q <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (!stop_p) begin
                        if (start_p && !door_s2_q) begin
                            state_q <= S_COOK;
                            time_q  <= ADD_SEC;
                            presc_q <= '0;
                        end else if (add_p) begin
                            state_q <= S_SET;
                            time_q  <= ADD_SEC;
                        end
                    end
                end
                S_SET: begin
                    if (stop_p) begin
                        state_q <= S_IDLE;
                        time_q  <= '0;
                    end else if (start_p && !door_s2_q) begin
                        state_q <= S_COOK;
                        presc_q <= '0;
                    end else if (add_p) begin
                        time_q <= sat_add(time_q, ADD_SEC);
                    end
                end
                S_COOK: begin
                    if (stop_p || door_s2_q) begin
                        state_q <= S_PAUSE;
                    end else if (add_p && tick) begin
                        time_q <= sat_add(time_q, ADD_SEC - 10'd1);
                    end else if (add_p) begin
                        time_q <= sat_add(time_q, ADD_SEC);
                    end else if (tick) begin
                        if (time_q <= 10'd1) begin
                            time_q   <= '0;
                            state_q  <= S_DONE;
                            buzzer_q <= 1'b1;
                            buzz_q   <= '0;
                            presc_q  <= '0;
                        end else begin
                            time_q <= time_q - 10'd1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (stop_p) begin
                        state_q <= S_IDLE;
                        time_q  <= '0;
                    end else if (start_p && !door_s2_q) begin
                        state_q <= S_COOK;
                        presc_q <= '0;
                    end else if (add_p) begin
                        time_q <= sat_add(time_q, ADD_SEC);
                    end
                end
                S_DONE: begin
                    if (stop_p || door_s2_q) begin
                        state_q  <= S_IDLE;
                        buzzer_q <= 1'b0;
                    end else if (tick) begin
                        if (buzz_q == BUZZ_LAST) begin
                            state_q  <= S_IDLE;
                            buzzer_q <= 1'b0;
                        end else begin
                            buzz_q <= buzz_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    time_q   <= '0;
                    buzzer_q <= 1'b0;
                end
            endcase
        end
    end

    // Raw door level so the heater drops in the same cycle the door opens
    assign magnetron = (state_q == S_COOK) && !door_open;
    assign lamp      = (state_q == S_COOK) || door_open;
    assign buzzer    = buzzer_q;
    assign time_left = time_q;
    assign state     = state_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Scenario bench for microwave_ctrl with TICK_DIV=4, BUZZ_SEC=2; expectations are queued
// when stimulus is applied and popped when the DUT result is due.
module tb_microwave_ctrl;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SET   = 3'd1;
    localparam logic [2:0] COOK  = 3'd2;
    localparam logic [2:0] PAUSE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_ADD   = 2;

    logic       clk;
    logic       reset;
    logic       btn_start;
    logic       btn_stop;
    logic       btn_add;
    logic       door_open;
    logic       magnetron;
    logic       lamp;
    logic       buzzer;
    logic [9:0] time_left;
    logic [2:0] state;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [9:0] tl;
        logic       mag;
        logic       lmp;
        logic       buz;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    microwave_ctrl #(.TICK_DIV(4), .BUZZ_SEC(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .btn_add   (btn_add),
        .door_open (door_open),
        .magnetron (magnetron),
        .lamp      (lamp),
        .buzzer    (buzzer),
        .time_left (time_left),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, bench did not finish");
        $fatal(1);
    end

    function automatic void push(input string tag, input logic [2:0] st, input logic [9:0] tl,
                                 input logic mag, input logic lmp, input logic buz);
        exp_t x;
        x.tag = tag;
        x.st  = st;
        x.tl  = tl;
        x.mag = mag;
        x.lmp = lmp;
        x.buz = buz;
        sb.push_back(x);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Button high for one cycle; returns right after the edge where the FSM reacts
    task automatic press(input int which);
        case (which)
            BTN_START: btn_start = 1'b1;
            BTN_STOP:  btn_stop  = 1'b1;
            default:   btn_add   = 1'b1;
        endcase
        step(1);
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        btn_add   = 1'b0;
        step(2);
    endtask

    task automatic test_reset;
        reset = 1'b1; btn_start = 1'b0; btn_stop = 1'b0; btn_add = 1'b0; door_open = 1'b0;
        #1;
        push("reset_idle", IDLE, 10'd0, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front(); n_checks++;
        if ({state, time_left, magnetron, lamp, buzzer} !== {e.st, e.tl, e.mag, e.lmp, e.buz}) begin
            n_fail++;
            $display("FAIL %s: got st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b want st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b", e.tag, state, time_left, magnetron, lamp, buzzer, e.st, e.tl, e.mag, e.lmp, e.buz);
        end
        door_open = 1'b1;
        #1;
        push("reset_lamp_follows_door", IDLE, 10'd0, 1'b0, 1'b1, 1'b0);
        e = sb.pop_front(); n_checks++;
        if ({state, time_left, magnetron, lamp, buzzer} !== {e.st, e.tl, e.mag, e.lmp, e.buz}) begin
            n_fail++;
            $display("FAIL %s: got st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b want st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b", e.tag, state, time_left, magnetron, lamp, buzzer, e.st, e.tl, e.mag, e.lmp, e.buz);
        end
        door_open = 1'b0;
        step(2);
        reset = 1'b0;
        step(3);
        push("idle_after_release", IDLE, 10'd0, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front(); n_checks++;
        if ({state, time_left, magnetron, lamp, buzzer} !== {e.st, e.tl, e.mag, e.lmp, e.buz}) begin
            n_fail++;
            $display("FAIL %s: got st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b want st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b", e.tag, state, time_left, magnetron, lamp, buzzer, e.st, e.tl, e.mag, e.lmp, e.buz);
        end
    endtask

    task automatic test_start_cook;
        push("s1_cook_at_edge3", COOK, 10'd30, 1'b1, 1'b1, 1'b0);
        press(BTN_START);
        push("s1_no_tick_before_4", COOK, 10'd30, 1'b1, 1'b1, 1'b0);
        push("s1_first_tick", COOK, 10'd29, 1'b1, 1'b1, 1'b0);
        push("s1_stop_pauses", PAUSE, 10'd29, 1'b0, 1'b0, 1'b0);
        push("s1_stop_clears", IDLE, 10'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) step(3);
            if (i == 2) step(1);
            if (i == 3) press(BTN_STOP);
            if (i == 4) press(BTN_STOP);
            e = sb.pop_front(); n_checks++;
            if ({state, time_left, magnetron, lamp, buzzer} !== {e.st, e.tl, e.mag, e.lmp, e.buz}) begin
                n_fail++;
                $display("FAIL %s: got st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b want st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b", e.tag, state, time_left, magnetron, lamp, buzzer, e.st, e.tl, e.mag, e.lmp, e.buz);
            end
        end
    endtask

    task automatic test_cook_done;
        for (int i = 1; i <= 3; i++) begin
            push($sformatf("s2_add_%0d", i), SET, 10'(30 * i), 1'b0, 1'b0, 1'b0);
            press(BTN_ADD);
            e = sb.pop_front(); n_checks++;
            if ({state, time_left, magnetron, lamp, buzzer} !== {e.st, e.tl, e.mag, e.lmp, e.buz}) begin
                n_fail++;
                $display("FAIL %s: got st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b want st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b", e.tag, state, time_left, magnetron, lamp, buzzer, e.st, e.tl, e.mag, e.lmp, e.buz);
            end
        end
        push("s2_cook_90", COOK, 10'd90, 1'b1, 1'b1, 1'b0);
        press(BTN_START);
        push("s2_last_second", COOK, 10'd1, 1'b1, 1'b1, 1'b0);
        push("s2_done_buzzer", DONE, 10'd0, 1'b0, 1'b0, 1'b1);
        push("s2_buzzer_still_on", DONE, 10'd0, 1'b0, 1'b0, 1'b1);
        push("s2_back_to_idle", IDLE, 10'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) step(359);
            if (i == 2) step(1);
            if (i == 3) step(7);
            if (i == 4) step(1);
            e = sb.pop_front(); n_checks++;
            if ({state, time_left, magnetron, lamp, buzzer} !== {e.st, e.tl, e.mag, e.lmp, e.buz}) begin
                n_fail++;
                $display("FAIL %s: got st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b want st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b", e.tag, state, time_left, magnetron, lamp, buzzer, e.st, e.tl, e.mag, e.lmp, e.buz);
            end
        end
    endtask

    task automatic test_pause_door;
        push("s3_cook_30", COOK, 10'd30, 1'b1, 1'b1, 1'b0);
        press(BTN_START);
        push("s3_at_12", COOK, 10'd12, 1'b1, 1'b1, 1'b0);
        push("s3_magnetron_drops_now", COOK, 10'd12, 1'b0, 1'b1, 1'b0);
        push("s3_paused_12", PAUSE, 10'd12, 1'b0, 1'b1, 1'b0);
        push("s3_resume_12", COOK, 10'd12, 1'b1, 1'b1, 1'b0);
        push("s3_resume_no_tick_yet", COOK, 10'd12, 1'b1, 1'b1, 1'b0);
        push("s3_resume_tick_after_4", COOK, 10'd11, 1'b1, 1'b1, 1'b0);
        push("s3_stop_pauses", PAUSE, 10'd11, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 1) step(72);
            if (i == 2) begin door_open = 1'b1; #1; end
            if (i == 3) step(3);
            if (i == 4) begin
                door_open = 1'b0; btn_start = 1'b1;
                step(1);
                btn_start = 1'b0;
                step(2);
            end
            if (i == 5) step(3);
            if (i == 6) step(1);
            if (i == 7) press(BTN_STOP);
            e = sb.pop_front(); n_checks++;
            if ({state, time_left, magnetron, lamp, buzzer} !== {e.st, e.tl, e.mag, e.lmp, e.buz}) begin
                n_fail++;
                $display("FAIL %s: got st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b want st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b", e.tag, state, time_left, magnetron, lamp, buzzer, e.st, e.tl, e.mag, e.lmp, e.buz);
            end
        end
        press(BTN_STOP);
    endtask

    task automatic test_saturate;
        int v;
        for (int i = 1; i <= 40; i++) begin
            v = 30 * i;
            if (v > 990) v = 990;
            push($sformatf("s4_add_%0d", i), SET, 10'(v), 1'b0, 1'b0, 1'b0);
            press(BTN_ADD);
            e = sb.pop_front(); n_checks++;
            if ({state, time_left, magnetron, lamp, buzzer} !== {e.st, e.tl, e.mag, e.lmp, e.buz}) begin
                n_fail++;
                $display("FAIL %s: got st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b want st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b", e.tag, state, time_left, magnetron, lamp, buzzer, e.st, e.tl, e.mag, e.lmp, e.buz);
            end
        end
        push("s4_stop_clears", IDLE, 10'd0, 1'b0, 1'b0, 1'b0);
        push("s4_cook_30", COOK, 10'd30, 1'b1, 1'b1, 1'b0);
        push("s4_at_1", COOK, 10'd1, 1'b1, 1'b1, 1'b0);
        push("s4_add_with_tick", COOK, 10'd30, 1'b1, 1'b1, 1'b0);
        push("s4_next_tick", COOK, 10'd29, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) press(BTN_STOP);
            if (i == 1) press(BTN_START);
            if (i == 2) step(116);
            if (i == 3) begin
                step(1);
                btn_add = 1'b1;
                step(1);
                btn_add = 1'b0;
                step(2);
            end
            if (i == 4) step(4);
            e = sb.pop_front(); n_checks++;
            if ({state, time_left, magnetron, lamp, buzzer} !== {e.st, e.tl, e.mag, e.lmp, e.buz}) begin
                n_fail++;
                $display("FAIL %s: got st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b want st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b", e.tag, state, time_left, magnetron, lamp, buzzer, e.st, e.tl, e.mag, e.lmp, e.buz);
            end
        end
        press(BTN_STOP);
        press(BTN_STOP);
    endtask

    task automatic test_back_to_back;
        push("s5_start_door_open_ignored", IDLE, 10'd0, 1'b0, 1'b1, 1'b0);
        push("s5_set_30", SET, 10'd30, 1'b0, 1'b0, 1'b0);
        push("s5_start_stop_same_cycle", IDLE, 10'd0, 1'b0, 1'b0, 1'b0);
        push("s5_held_add_one_pulse", SET, 10'd30, 1'b0, 1'b0, 1'b0);
        push("s5_release_no_pulse", SET, 10'd30, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin door_open = 1'b1; press(BTN_START); end
            if (i == 1) begin door_open = 1'b0; step(2); press(BTN_ADD); end
            if (i == 2) begin
                btn_start = 1'b1; btn_stop = 1'b1;
                step(1);
                btn_start = 1'b0; btn_stop = 1'b0;
                step(2);
            end
            if (i == 3) begin btn_add = 1'b1; step(100); end
            if (i == 4) begin btn_add = 1'b0; step(3); end
            e = sb.pop_front(); n_checks++;
            if ({state, time_left, magnetron, lamp, buzzer} !== {e.st, e.tl, e.mag, e.lmp, e.buz}) begin
                n_fail++;
                $display("FAIL %s: got st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b want st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b", e.tag, state, time_left, magnetron, lamp, buzzer, e.st, e.tl, e.mag, e.lmp, e.buz);
            end
        end
        press(BTN_STOP);
    endtask

    task automatic test_async_reset;
        push("s6_cook_30", COOK, 10'd30, 1'b1, 1'b1, 1'b0);
        push("s6_reset_drops_magnetron", IDLE, 10'd0, 1'b0, 1'b0, 1'b0);
        push("s6_idle_after_release", IDLE, 10'd0, 1'b0, 1'b0, 1'b0);
        push("s6_held_button_one_pulse", SET, 10'd30, 1'b0, 1'b0, 1'b0);
        push("s6_held_no_second_pulse", SET, 10'd30, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) press(BTN_START);
            if (i == 1) begin step(2); #3; reset = 1'b1; #1; end
            if (i == 2) begin btn_add = 1'b1; step(2); reset = 1'b0; step(1); end
            if (i == 3) step(2);
            if (i == 4) step(10);
            e = sb.pop_front(); n_checks++;
            if ({state, time_left, magnetron, lamp, buzzer} !== {e.st, e.tl, e.mag, e.lmp, e.buz}) begin
                n_fail++;
                $display("FAIL %s: got st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b want st=%0d tl=%0d mag=%0b lamp=%0b buz=%0b", e.tag, state, time_left, magnetron, lamp, buzzer, e.st, e.tl, e.mag, e.lmp, e.buz);
            end
        end
        btn_add = 1'b0;
        press(BTN_STOP);
    endtask

    initial begin
        test_reset();
        test_start_cook();
        test_cook_done();
        test_pause_door();
        test_saturate();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
